// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: response owner, in-flight tag, latency bound.
package mem_arb_pkg;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  typedef struct packed {
    logic   v;
    owner_e own;
    logic   we;
  } arb_tag_t;

  localparam int MAX_LAT = 4;

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// MEM_LAT-deep shift register of response tags; the head lines up with mem_rdata.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  if (MEM_LAT < 1 || MEM_LAT > MAX_LAT) begin : g_bad_lat
    $error("arb_tag_pipe: MEM_LAT must be within 1..MAX_LAT");
  end

  arb_tag_t tag_p [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port fixed-latency memory.
// MEM_ARB_RR_EN selects round-robin arbitration instead of data priority with starvation escape.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic     grant_if, grant_d;
  arb_tag_t tag_in, tag_head;

`ifdef MEM_ARB_RR_EN
  // rr_ptr names the port that wins the next conflict.
  owner_e rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= OWN_IF;
    else if (if_gnt) rr_ptr <= OWN_D;
    else if (d_gnt)  rr_ptr <= OWN_IF;
  end

  always_comb begin
    grant_d  = d_req && !(if_req && rr_ptr == OWN_IF);
    grant_if = if_req && !grant_d;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst)                     starve_cnt <= '0;
    else if (!if_req || grant_if) starve_cnt <= '0;
    else if (!starved)           starve_cnt <= starve_cnt + CNT_W'(1);
  end

  always_comb begin
    grant_d  = d_req && !(if_req && starved);
    grant_if = if_req && !grant_d;
  end
`endif

  assign if_gnt = !rst && grant_if;
  assign d_gnt  = !rst && grant_d;

  // Issue stage: drive the memory from the granted port.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    tag_in    = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
      tag_in.v  = 1'b1;
      tag_in.own = OWN_D;
      tag_in.we = d_we;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      tag_in.v  = 1'b1;
      tag_in.own = OWN_IF;
    end
  end

  arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_head)
  );

  // Response stage: route mem_rdata to the owner of the head tag.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!rst && tag_head.v) begin
      if (tag_head.own == OWN_D) begin
        d_rvalid = 1'b1;
        if (!tag_head.we) d_rdata = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected responses, a monitor pops them.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        l3_rst;
  logic        l3_if_req, l3_if_gnt, l3_if_rvalid;
  logic [31:0] l3_if_addr, l3_if_rdata;
  logic        l3_d_req, l3_d_we, l3_d_gnt, l3_d_rvalid;
  logic [31:0] l3_d_addr, l3_d_wdata, l3_d_rdata;
  logic [3:0]  l3_d_wstrb;
  logic        l3_mem_en, l3_mem_we;
  logic [31:0] l3_mem_addr, l3_mem_wdata;
  logic [31:0] l3_mem_rdata = 32'h5A5A_5A5A;
  logic [3:0]  l3_mem_wstrb;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(l3_rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_rvalid(l3_if_rvalid),
    .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata), .d_wstrb(l3_d_wstrb),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_wstrb(l3_mem_wstrb), .mem_rdata(l3_mem_rdata)
  );

  // Memory model, 256 words, one-cycle read latency.
  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h0 : (32'hA000_0000 | 32'(i));
  endfunction

  logic [31:0] mem [256];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      rd_q <= '0;
    end else if (mem_en) begin
      rd_q <= mem[mem_addr[9:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t exp_if[$];
  exp_t exp_d[$];
  exp_t e_if, e_d;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid) begin
        if (exp_if.size() == 0) chk("if_unexpected_rvalid", 1, 0);
        else begin
          e_if = exp_if.pop_front();
          chk("if_rdata", if_rdata, e_if.data);
          chk("if_resp_cycle", 64'(cyc), 64'(e_if.at));
        end
      end else chk("if_rdata_idle", if_rdata, 0);
      if (d_rvalid) begin
        if (exp_d.size() == 0) chk("d_unexpected_rvalid", 1, 0);
        else begin
          e_d = exp_d.pop_front();
          chk("d_rdata", d_rdata, e_d.data);
          chk("d_resp_cycle", 64'(cyc), 64'(e_d.at));
        end
      end else chk("d_rdata_idle", d_rdata, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; l3_rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    l3_if_req = 0; l3_if_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0;
    l3_d_wdata = '0; l3_d_wstrb = '0;
    tick();

    // Outputs held at zero during reset even with both ports requesting.
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF;
    d_wstrb = 4'hF;
    mid();
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    tick();
    rst = 0; l3_rst = 0;
    if_req = 0; d_req = 0; d_we = 0; d_wdata = '0; d_wstrb = '0;
    tick();

`ifdef MEM_ARB_RR_EN
    // Continuous contention alternates, fetch first.
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("rr_if_gnt", if_gnt, (k % 2 == 0));
      chk("rr_d_gnt", d_gnt, (k % 2 == 1));
      if (k % 2 == 0) exp_if.push_back('{32'hA000_0004, cyc + 1});
      else            exp_d.push_back('{32'hA000_0040, cyc + 1});
      tick();
    end
    if_req = 0; d_req = 0;
    tick();
`endif

    // Back-to-back fetches.
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = 32'(4 * i);
      mid();
      chk("t1_if_gnt", if_gnt, 1);
      chk("t1_d_gnt", d_gnt, 0);
      chk("t1_mem_en", mem_en, 1);
      chk("t1_mem_addr", mem_addr, 64'(4 * i));
      exp_if.push_back('{32'hA000_0000 | 32'(i), cyc + 1});
      tick();
    end
    if_req = 0;
    tick();

`ifndef MEM_ARB_RR_EN
    // Data wins a conflict; fetch follows next cycle.
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h100;
    mid();
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_if_gnt", if_gnt, 0);
    exp_d.push_back('{32'hA000_0040, cyc + 1});
    tick();
    d_req = 0;
    mid();
    chk("t2_if_gnt_next", if_gnt, 1);
    chk("t2_mem_addr", mem_addr, 32'h10);
    exp_if.push_back('{32'hA000_0004, cyc + 1});
    tick();
    if_req = 0;
    tick();

    // Starvation escape every fifth cycle under sustained data traffic.
    if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("t3_if_gnt", if_gnt, (k % 5 == 4));
      chk("t3_d_gnt", d_gnt, (k % 5 != 4));
      if (k % 5 == 4) exp_if.push_back('{32'hA000_0008, cyc + 1});
      else            exp_d.push_back('{32'hA000_0020, cyc + 1});
      tick();
    end
    if_req = 0; d_req = 0;
    tick();

    // A fetch denied once and then dropped must produce no response.
    if_req = 1; if_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h0;
    mid();
    chk("wd_if_gnt", if_gnt, 0);
    exp_d.push_back('{32'hA000_0000, cyc + 1});
    tick();
    if_req = 0; d_req = 0;
    tick();
`endif

    // Partial store, ack with zero data, then read back.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    mid();
    chk("t4_st_gnt", d_gnt, 1);
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_wstrb", mem_wstrb, 4'b0011);
    chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t4_mem_addr", mem_addr, 32'h40);
    exp_d.push_back('{32'h0, cyc + 1});
    tick();
    d_we = 0; d_wdata = '0; d_wstrb = '0;
    mid();
    chk("t4_ld_gnt", d_gnt, 1);
    chk("t4_ld_mem_we", mem_we, 0);
    exp_d.push_back('{32'h0000_BEEF, cyc + 1});
    tick();
    d_we = 1; d_addr = 32'h48; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    mid();
    chk("t4_st2_gnt", d_gnt, 1);
    exp_d.push_back('{32'h0, cyc + 1});
    tick();
    d_req = 0; d_we = 0; d_wdata = '0; d_wstrb = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("drain_if_queue", exp_if.size(), 0);
    chk("drain_d_queue", exp_d.size(), 0);

    // MEM_LAT=3 instance: reset drops two in-flight fetches.
    l3_if_req = 1; l3_if_addr = 32'h40;
    mid();
    chk("t5_gnt0", l3_if_gnt, 1);
    tick();
    mid();
    chk("t5_gnt1", l3_if_gnt, 1);
    tick();
    l3_rst = 1;
    mid();
    chk("t5_rst_if_gnt", l3_if_gnt, 0);
    chk("t5_rst_d_gnt", l3_d_gnt, 0);
    chk("t5_rst_mem_en", l3_mem_en, 0);
    chk("t5_rst_mem_addr", l3_mem_addr, 0);
    chk("t5_rst_if_rvalid", l3_if_rvalid, 0);
    chk("t5_rst_if_rdata", l3_if_rdata, 0);
    tick();
    l3_rst = 0; l3_if_req = 0;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("t5_post_rst_if_rvalid", l3_if_rvalid, 0);
      chk("t5_post_rst_d_rvalid", l3_d_rvalid, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
